// File: rtl/benes_pipe_net.sv
// Pipelined N x N Benes permutation network with a double-buffered switch config and a drain-then-swap commit.
// Latency is STAGES cycles from accept to hand-off. One global stall: every rank holds while out_valid & !out_ready.
module benes_pipe_net #(
  parameter  int N_PORTS    = 16,
  parameter  int DATA_W     = 4,
  localparam int L          = $clog2(N_PORTS),
  localparam int STAGES     = 2*L - 1,
  localparam int SW_PER_STG = N_PORTS/2,
  localparam int SEL_W      = $clog2(STAGES),
  localparam int BUS_W      = N_PORTS*DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BUS_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BUS_W-1:0]      out_data,
  input  logic                  cfg_wr,
  input  logic [SEL_W-1:0]      cfg_stage,
  input  logic [SW_PER_STG-1:0] cfg_bits,
  input  logic                  cfg_commit,
  output logic                  cfg_busy
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                  advance;
  logic                  in_fire;
  logic                  pipe_empty;
  logic                  do_swap;

  logic [SW_PER_STG-1:0] shadow_cfg [STAGES];
  logic [SW_PER_STG-1:0] active_cfg [STAGES];

  logic [BUS_W-1:0]      stage_in [STAGES];
  logic [BUS_W-1:0]      sw_out   [STAGES];
  logic [BUS_W-1:0]      rank_dat [STAGES];
  logic [STAGES-1:0]     rank_vld;

  assign out_valid  = rank_vld[STAGES-1];
  assign out_data   = rank_dat[STAGES-1];
  assign advance    = !out_valid || out_ready;
  assign in_fire    = in_valid && in_ready;
  assign pipe_empty = (rank_vld == '0);

  assign stage_in[0] = in_data;

  // Each stage: SW_PER_STG 2x2 switches on lane pairs (2k, 2k+1).
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    for (genvar k = 0; k < SW_PER_STG; k++) begin : g_sw
      localparam int LO = 2*k*DATA_W;
      localparam int HI = (2*k + 1)*DATA_W;
      assign sw_out[s][LO +: DATA_W] = active_cfg[s][k] ? stage_in[s][HI +: DATA_W]
                                                        : stage_in[s][LO +: DATA_W];
      assign sw_out[s][HI +: DATA_W] = active_cfg[s][k] ? stage_in[s][LO +: DATA_W]
                                                        : stage_in[s][HI +: DATA_W];
    end
  end

  // Front half unshuffles in shrinking blocks, back half shuffles in growing blocks,
  // so with all switches passing the two halves cancel to the identity.
  for (genvar s = 0; s < STAGES-1; s++) begin : g_wire
    localparam bit UNSH = (s < L-1);
    localparam int BLK  = UNSH ? (N_PORTS >> s) : (1 << (UNSH ? 0 : (s - L + 3)));
    for (genvar j = 0; j < N_PORTS; j++) begin : g_lane
      localparam int JJ   = j % BLK;
      localparam int BASE = j - JJ;
      localparam int SRC  = BASE + (UNSH ? ((JJ < BLK/2) ? 2*JJ : 2*(JJ - BLK/2) + 1)
                                         : ((JJ >> 1) + (JJ % 2)*(BLK/2)));
      assign stage_in[s+1][j*DATA_W +: DATA_W] = rank_dat[s][SRC*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rank_vld <= '0;
      for (int s = 0; s < STAGES; s++) begin
        rank_dat[s] <= '0;
      end
    end else if (advance) begin
      rank_vld <= {rank_vld[STAGES-2:0], in_fire};
      for (int s = 0; s < STAGES; s++) begin
        rank_dat[s] <= sw_out[s];
      end
    end
  end

  // Rows at or above STAGES are silently dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        shadow_cfg[s] <= '0;
      end
    end else if (cfg_wr && (int'(cfg_stage) < STAGES)) begin
      shadow_cfg[cfg_stage] <= cfg_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        active_cfg[s] <= '0;
      end
    end else if (do_swap) begin
      active_cfg <= shadow_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Extra commits while busy fall through: only RUN reacts to cfg_commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_commit) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = SWAP;
      SWAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_ready = advance && (state_q == RUN);
    cfg_busy = (state_q != RUN);
    do_swap  = (state_q == SWAP);
  end

endmodule

// File: tb/tb_benes_pipe_net.sv
// Directed and table-driven checks of benes_pipe_net at 16x4, plus random configs at 8x8 against a lane model.
module tb_benes_pipe_net;

  localparam int SA = 7;
  localparam int SB = 5;

  typedef logic [7:0] cfg_arr_t [7];

  typedef struct {
    cfg_arr_t    cfg;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0] exp;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic        cfg_wr, cfg_commit, cfg_busy;
  logic [2:0]  cfg_stage;
  logic [7:0]  cfg_bits;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic        b_cfg_wr, b_cfg_commit, b_cfg_busy;
  logic [2:0]  b_cfg_stage;
  logic [3:0]  b_cfg_bits;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q [$];
  vec_t vt [6];

  benes_pipe_net #(.N_PORTS(16), .DATA_W(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_wr(cfg_wr), .cfg_stage(cfg_stage), .cfg_bits(cfg_bits),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy)
  );

  benes_pipe_net #(.N_PORTS(8), .DATA_W(8)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .cfg_wr(b_cfg_wr), .cfg_stage(b_cfg_stage), .cfg_bits(b_cfg_bits),
    .cfg_commit(b_cfg_commit), .cfg_busy(b_cfg_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane-level reference: switches, then the block (un)shuffle between stages.
  function automatic logic [63:0] model(input int n, input int dw, input logic [63:0] din,
                                        input cfg_arr_t cfg);
    int l, st, b, jj, src, t;
    int cur [16];
    int nxt [16];
    logic [63:0] r;
    l  = $clog2(n);
    st = 2*l - 1;
    for (int i = 0; i < n; i++) cur[i] = int'((din >> (i*dw)) & ((64'd1 << dw) - 64'd1));
    for (int s = 0; s < st; s++) begin
      for (int k = 0; k < n/2; k++) begin
        if (cfg[s][k]) begin
          t = cur[2*k]; cur[2*k] = cur[2*k+1]; cur[2*k+1] = t;
        end
      end
      if (s < st-1) begin
        b = (s < l-1) ? (n >> s) : (1 << (s - l + 3));
        for (int j = 0; j < n; j++) begin
          jj = j % b;
          if (s < l-1) src = (jj < b/2) ? 2*jj : 2*(jj - b/2) + 1;
          else         src = (jj >> 1) + (jj % 2)*(b/2);
          nxt[j] = cur[j - jj + src];
        end
        for (int j = 0; j < n; j++) cur[j] = nxt[j];
      end
    end
    r = '0;
    for (int i = 0; i < n; i++) r = r | (64'(cur[i]) << (i*dw));
    return r;
  endfunction

  function automatic logic [63:0] mk16(input int b);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = 4'((i + b) % 16);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data_a", out_data, e.exp);
        if (e.lat) chk("latency_a", 64'(cyc - e.acc + 1), 64'(SA));
      end
    end
  end

  task automatic write_rows_a(input cfg_arr_t c);
    for (int s = 0; s < SA; s++) begin
      cfg_wr = 1'b1; cfg_stage = 3'(s); cfg_bits = c[s];
      tick();
    end
    cfg_stage = 3'd7; cfg_bits = 8'h5A;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic load_cfg_a(input cfg_arr_t c);
    int n = 0;
    write_rows_a(c);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    while (cfg_busy && n < 50) begin tick(); n++; end
    if (n >= 50) chk("commit_timeout_a", 64'(cfg_busy), 64'd0);
  endtask

  task automatic send_a(input logic [63:0] d, input logic [63:0] x, input bit lat, input bit commit);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1; in_data = d; cfg_commit = commit;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("accept_timeout_a", 64'(in_ready), 64'd1);
    tick();
    cfg_commit = 1'b0;
    e.exp = x; e.acc = cyc; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic drain_a();
    int n = 0;
    while (q.size() != 0 && n < 200) begin tick(); n++; end
    chk("drain_a", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    cfg_arr_t    cfg_old, cfg_new, cb;
    logic [63:0] din, d0;
    int          acc3, acc4, n, acc;

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_wr = 1'b0; cfg_stage = '0; cfg_bits = '0; cfg_commit = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    b_cfg_wr = 1'b0; b_cfg_stage = '0; b_cfg_bits = '0; b_cfg_commit = 1'b0;

    for (int v = 0; v < 6; v++) vt[v].cfg = '{default: 8'h00};
    vt[0].din = 64'hFEDCBA9876543210; vt[0].exp = 64'hFEDCBA9876543210;
    vt[1].cfg[0] = 8'hFF;
    vt[1].din = 64'hFEDCBA9876543210; vt[1].exp = 64'hEFCDAB8967452301;
    vt[2].cfg[0] = 8'hFF; vt[2].cfg[6] = 8'hFF;
    vt[2].din = 64'hFEDCBA9876543210; vt[2].exp = 64'hFEDCBA9876543210;
    vt[3].cfg[6] = 8'hFF;
    vt[3].din = 64'h0123456789ABCDEF; vt[3].exp = 64'h1032547698BADCFE;
    vt[4].cfg[3] = 8'h01;
    vt[4].din = 64'hFEDCBA9876543210; vt[4].exp = 64'hFEDCBA9076543218;
    vt[5].cfg[0] = 8'h01;
    vt[5].din = 64'hFEDCBA9876543210; vt[5].exp = 64'hFEDCBA9876543201;

    tick(); tick();
    rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data",  out_data, 64'd0);
    chk("reset_cfg_busy",  64'(cfg_busy), 64'd0);
    chk("reset_in_ready",  64'(in_ready), 64'd1);

    // Single beat through the reset (all-pass) config.
    send_a(64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain_a();
    chk("single_pulse_valid", 64'(out_valid), 64'd0);

    for (int v = 0; v < 6; v++) begin
      load_cfg_a(vt[v].cfg);
      send_a(vt[v].din, vt[v].exp, 1'b1, 1'b0);
      in_valid = 1'b0;
      drain_a();
    end

    // Commit into an empty pipe: DRAIN then SWAP.
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n = 0;
    while (cfg_busy && n < 20) begin
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      n++;
      tick();
    end
    chk("empty_commit_busy_cycles", 64'(n), 64'd2);

    // Commit issued with beat 3 of a back-to-back stream.
    cfg_old = '{default: 8'h00}; cfg_old[0] = 8'hFF;
    cfg_new = '{default: 8'h00};
    load_cfg_a(cfg_old);
    write_rows_a(cfg_new);
    acc3 = 0; acc4 = 0;
    for (int b = 0; b < 10; b++) begin
      din = mk16(b);
      if (b <= 3) send_a(din, model(16, 4, din, cfg_old), 1'b1, b == 3);
      else        send_a(din, model(16, 4, din, cfg_new), 1'b1, 1'b0);
      if (b == 3) acc3 = cyc;
      if (b == 4) acc4 = cyc;
    end
    in_valid = 1'b0;
    drain_a();
    chk("commit_gap_in_range", 64'((acc4 - acc3 >= SA + 2) && (acc4 - acc3 <= SA + 3)), 64'd1);

    // Full pipe under a 5-cycle downstream stall.
    out_ready = 1'b0;
    d0 = mk16(20);
    for (int b = 0; b < 7; b++) send_a(mk16(20 + b), mk16(20 + b), 1'b0, 1'b0);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_data",  out_data, d0);
      chk("stall_in_ready",  64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    drain_a();

    // Reset in the middle of a stream with a crossing config loaded.
    load_cfg_a(cfg_old);
    for (int b = 0; b < 4; b++) send_a(mk16(b), model(16, 4, mk16(b), cfg_old), 1'b1, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    q.delete();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    chk("midrst_out_data",  out_data, 64'd0);
    chk("midrst_cfg_busy",  64'(cfg_busy), 64'd0);
    chk("midrst_in_ready",  64'(in_ready), 64'd1);
    send_a(64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 1'b1, 1'b0);
    in_valid = 1'b0;
    drain_a();

    // 8x8 instance: random configs and beats.
    for (int it = 0; it < 1000; it++) begin
      cb = '{default: 8'h00};
      for (int s = 0; s < SB; s++) cb[s] = 8'($urandom_range(0, 15));
      for (int s = 0; s < SB; s++) begin
        b_cfg_wr = 1'b1; b_cfg_stage = 3'(s); b_cfg_bits = cb[s][3:0];
        tick();
      end
      b_cfg_stage = 3'(SB + it % 3); b_cfg_bits = 4'($urandom_range(0, 15));
      tick();
      b_cfg_wr = 1'b0;
      b_cfg_commit = 1'b1;
      tick();
      b_cfg_commit = 1'b0;
      n = 0;
      while (b_cfg_busy && n < 50) begin tick(); n++; end
      if (n >= 50) chk("commit_timeout_b", 64'(b_cfg_busy), 64'd0);
      din = {$urandom, $urandom};
      b_in_valid = 1'b1; b_in_data = din;
      n = 0;
      while (!b_in_ready && n < 50) begin tick(); n++; end
      if (n >= 50) chk("accept_timeout_b", 64'(b_in_ready), 64'd1);
      tick();
      acc = cyc;
      b_in_valid = 1'b0;
      n = 0;
      while (!b_out_valid && n < 20) begin tick(); n++; end
      chk("out_data_b", b_out_data, model(8, 8, din, cb));
      chk("latency_b", 64'(cyc - acc + 1), 64'(SB));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
